drt_enumerator: RTL and testbench

//  Wishbone master that walks the Device ROM Table (DRT) to find a device by type ID.
//  On start it reads the DRT header (device count), then scans each 4-word device entry.
//  It reports the first entry whose ID matches, along with that entry's info, memory offset and size.

---
 rtl/drt_pkg.sv | 36 +++
 rtl/drt_wb_read_port.sv | 84 ++++++++
 rtl/drt_enumerator.sv | 180 ++++++++++++++++++
 tb/tb_drt_enumerator.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/drt_pkg.sv
// Shared DRT layout constants, scan/read-port state encodings and entry address helper.
// No logic of its own; no latency or backpressure.
package drt_pkg;

    localparam logic [31:0] DRT_SIZE_OF_HEADER = 32'd4;
    localparam logic [31:0] DRT_SIZE_OF_DEV    = 32'd4;
    localparam logic [31:0] DRT_NUM_DEV_OFF    = 32'd1;
    localparam logic [31:0] DEV_ID_OFF         = 32'd0;
    localparam logic [31:0] DEV_INFO_OFF       = 32'd1;
    localparam logic [31:0] DEV_MEM_OFF_OFF    = 32'd2;
    localparam logic [31:0] DEV_SIZE_OFF       = 32'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_NUM,
        ST_RD_ID,
        ST_RD_INFO,
        ST_RD_OFF,
        ST_RD_SIZE,
        ST_FINISH
    } drt_state_t;

    typedef enum logic [1:0] {
        RP_IDLE,
        RP_BUSY,
        RP_RELEASE
    } rp_state_t;

    // Word address of one word of device entry idx; wraps modulo 2^32.
    function automatic logic [31:0] dev_word_adr(input logic [31:0] base,
                                                 input logic [7:0]  idx,
                                                 input logic [31:0] off);
        return base + DRT_SIZE_OF_HEADER + DRT_SIZE_OF_DEV * {24'd0, idx} + off;
    endfunction

endpackage

// File: rtl/drt_wb_read_port.sv
// Single wishbone read with ack timeout; stb rises the cycle after req, rdy/data are valid in the ack cycle.
// Holds cyc/stb until ack or TIMEOUT_CYCLES; waits for ack to fall before accepting the next req.
module drt_wb_read_port
    import drt_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic [31:0] adr,
    output logic        rdy,
    output logic [31:0] data,
    output logic        timeout,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic [31:0] wbm_adr_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    rp_state_t        state;
    rp_state_t        state_nxt;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= RP_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        rdy       = 1'b0;
        timeout   = 1'b0;
        case (state)
            RP_IDLE: begin
                if (req && !wbm_ack_i) begin
                    state_nxt = RP_BUSY;
                end
            end
            RP_BUSY: begin
                if (wbm_ack_i) begin
                    rdy       = 1'b1;
                    state_nxt = RP_RELEASE;
                end else if (cnt == CNT_LAST) begin
                    timeout   = 1'b1;
                    state_nxt = RP_IDLE;
                end
            end
            RP_RELEASE: begin
                // The slave holds ack until it sees stb low.
                if (!wbm_ack_i) begin
                    state_nxt = RP_IDLE;
                end
            end
            default: state_nxt = RP_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt       <= '0;
            wbm_adr_o <= '0;
        end else if (state == RP_IDLE) begin
            cnt <= '0;
            if (req && !wbm_ack_i) begin
                wbm_adr_o <= adr;
            end
        end else if (state == RP_BUSY) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign wbm_cyc_o = (state == RP_BUSY);
    assign wbm_stb_o = (state == RP_BUSY);
    assign data      = wbm_dat_i;

endmodule

// File: rtl/drt_enumerator.sv
// Walks the Device ROM Table for the first entry whose ID matches find_id; ~5 cycles per bus read.
// start is taken only in IDLE; bus stalls are absorbed by the read port up to its ack timeout.
module drt_enumerator
    import drt_pkg::*;
#(
    parameter logic [31:0] DRT_BASE_ADR   = 32'h0000_0000,
    parameter int unsigned MAX_DEVICES    = 16,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] find_id,
    output logic        busy,
    output logic        done,
    output logic        found,
    output logic        timeout_err,
    output logic [31:0] num_devices,
    output logic [7:0]  dev_index,
    output logic [31:0] dev_info,
    output logic [31:0] dev_mem_off,
    output logic [31:0] dev_mem_size,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i
);

    drt_state_t  state;
    drt_state_t  state_nxt;
    logic [7:0]  idx;
    logic [7:0]  n_dev;
    logic [7:0]  idx_inc;
    logic [7:0]  n_clamp;
    logic        id_match;
    logic        rd_req;
    logic        rd_rdy;
    logic        rd_timeout;
    logic [31:0] rd_adr;
    logic [31:0] rd_data;

    drt_wb_read_port #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_rd_port (
        .clk       (clk),
        .rst       (rst),
        .req       (rd_req),
        .adr       (rd_adr),
        .rdy       (rd_rdy),
        .data      (rd_data),
        .timeout   (rd_timeout),
        .wbm_cyc_o (wbm_cyc_o),
        .wbm_stb_o (wbm_stb_o),
        .wbm_adr_o (wbm_adr_o),
        .wbm_dat_i (wbm_dat_i),
        .wbm_ack_i (wbm_ack_i)
    );

    assign wbm_we_o  = 1'b0;
    assign wbm_sel_o = 4'hF;
    assign wbm_dat_o = 32'd0;

    assign id_match = (rd_data[15:0] == find_id);
    assign idx_inc  = idx + 8'd1;
    // Clamp on the full 32-bit count so e.g. 0x103 does not alias to 3.
    assign n_clamp  = (rd_data > 32'(MAX_DEVICES)) ? 8'(MAX_DEVICES) : rd_data[7:0];

    assign rd_req = (state inside {ST_RD_NUM, ST_RD_ID, ST_RD_INFO, ST_RD_OFF, ST_RD_SIZE});
    assign busy   = rd_req;
    assign done   = (state == ST_FINISH);

    always_comb begin
        rd_adr = DRT_BASE_ADR + DRT_NUM_DEV_OFF;
        case (state)
            ST_RD_ID:   rd_adr = dev_word_adr(DRT_BASE_ADR, idx, DEV_ID_OFF);
            ST_RD_INFO: rd_adr = dev_word_adr(DRT_BASE_ADR, idx, DEV_INFO_OFF);
            ST_RD_OFF:  rd_adr = dev_word_adr(DRT_BASE_ADR, idx, DEV_MEM_OFF_OFF);
            ST_RD_SIZE: rd_adr = dev_word_adr(DRT_BASE_ADR, idx, DEV_SIZE_OFF);
            default:    rd_adr = DRT_BASE_ADR + DRT_NUM_DEV_OFF;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (rd_timeout) begin
            state_nxt = ST_FINISH;
        end else begin
            case (state)
                ST_IDLE:    if (start) state_nxt = ST_RD_NUM;
                ST_RD_NUM:  if (rd_rdy) state_nxt = (n_clamp == 8'd0) ? ST_FINISH : ST_RD_ID;
                ST_RD_ID: begin
                    if (rd_rdy) begin
                        if (id_match) begin
                            state_nxt = ST_RD_INFO;
                        end else if (idx_inc == n_dev) begin
                            state_nxt = ST_FINISH;
                        end
                    end
                end
                ST_RD_INFO: if (rd_rdy) state_nxt = ST_RD_OFF;
                ST_RD_OFF:  if (rd_rdy) state_nxt = ST_RD_SIZE;
                ST_RD_SIZE: if (rd_rdy) state_nxt = ST_FINISH;
                ST_FINISH:  state_nxt = ST_IDLE;
                default:    state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            found        <= 1'b0;
            timeout_err  <= 1'b0;
            num_devices  <= '0;
            dev_index    <= '0;
            dev_info     <= '0;
            dev_mem_off  <= '0;
            dev_mem_size <= '0;
            idx          <= '0;
            n_dev        <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        found        <= 1'b0;
                        timeout_err  <= 1'b0;
                        num_devices  <= '0;
                        dev_index    <= '0;
                        dev_info     <= '0;
                        dev_mem_off  <= '0;
                        dev_mem_size <= '0;
                        idx          <= '0;
                        n_dev        <= '0;
                    end
                end
                ST_RD_NUM: begin
                    if (rd_rdy) begin
                        num_devices <= rd_data;
                        n_dev       <= n_clamp;
                        idx         <= '0;
                    end
                end
                ST_RD_ID: begin
                    if (rd_rdy) begin
                        if (id_match) begin
                            dev_index <= idx;
                        end else begin
                            idx <= idx_inc;
                        end
                    end
                end
                ST_RD_INFO: if (rd_rdy) dev_info <= rd_data;
                ST_RD_OFF:  if (rd_rdy) dev_mem_off <= rd_data;
                ST_RD_SIZE: begin
                    if (rd_rdy) begin
                        dev_mem_size <= rd_data;
                        found        <= 1'b1;
                    end
                end
                default: ;
            endcase
            if (rd_timeout) begin
                timeout_err <= 1'b1;
                found       <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_drt_enumerator.sv
// Drives drt_enumerator against a wishbone ROM slave and compares each scan with a table-walk model.
module tb_drt_enumerator;

    localparam logic [31:0] BASE = 32'hFFFF_FFF8;
    localparam int MAXD = 16;
    localparam int TO   = 64;
    localparam int LIM  = 3000;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] find_id;
    logic        busy, done, found, timeout_err;
    logic [31:0] num_devices, dev_info, dev_mem_off, dev_mem_size;
    logic [7:0]  dev_index;
    logic        cyc, stb, we, ack;
    logic [3:0]  sel;
    logic [31:0] adr, dat_o, dat_i, rel;

    drt_enumerator #(
        .DRT_BASE_ADR   (BASE),
        .MAX_DEVICES    (MAXD),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .find_id      (find_id),
        .busy         (busy),
        .done         (done),
        .found        (found),
        .timeout_err  (timeout_err),
        .num_devices  (num_devices),
        .dev_index    (dev_index),
        .dev_info     (dev_info),
        .dev_mem_off  (dev_mem_off),
        .dev_mem_size (dev_mem_size),
        .wbm_cyc_o    (cyc),
        .wbm_stb_o    (stb),
        .wbm_we_o     (we),
        .wbm_sel_o    (sel),
        .wbm_adr_o    (adr),
        .wbm_dat_o    (dat_o),
        .wbm_dat_i    (dat_i),
        .wbm_ack_i    (ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM slave: ack one cycle after stb, held until stb falls; mute models a dead slave.
    logic [31:0] rom [0:255];
    bit          mute;
    assign rel = adr - BASE;
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            ack   <= 1'b0;
            dat_i <= '0;
        end else begin
            ack   <= cyc && stb && !mute;
            dat_i <= rom[rel[7:0]];
        end
    end

    logic [31:0] rd_log [$];
    int          done_cnt = 0;
    always @(negedge clk) begin
        if (cyc && stb && ack) rd_log.push_back(adr);
        if (done) done_cnt++;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Reference: what a scan of the current ROM must return and which words it must read.
    logic        exp_found;
    logic [7:0]  exp_idx;
    logic [31:0] exp_num, exp_info, exp_off, exp_size;
    logic [31:0] exp_adr [$];

    task automatic model(input logic [15:0] id);
        int          n;
        logic [31:0] ent;
        exp_adr.delete();
        exp_found = 0; exp_idx = 0; exp_info = 0; exp_off = 0; exp_size = 0;
        exp_num = rom[1];
        exp_adr.push_back(BASE + 32'd1);
        n = (exp_num > 32'(MAXD)) ? MAXD : int'(exp_num);
        for (int i = 0; i < n; i++) begin
            ent = BASE + 32'(4 + 4 * i);
            exp_adr.push_back(ent);
            if (rom[4 + 4 * i][15:0] == id) begin
                exp_found = 1;
                exp_idx   = 8'(i);
                exp_info  = rom[5 + 4 * i];
                exp_off   = rom[6 + 4 * i];
                exp_size  = rom[7 + 4 * i];
                exp_adr.push_back(ent + 32'd1);
                exp_adr.push_back(ent + 32'd2);
                exp_adr.push_back(ent + 32'd3);
                break;
            end
        end
    endtask

    task automatic fill_rom(input logic [31:0] num);
        for (int i = 0; i < 256; i++) rom[i] = $urandom;
        rom[1] = num;
    endtask

    task automatic set_id(input int i, input logic [15:0] id);
        rom[4 + 4 * i] = {16'($urandom), id};
    endtask

    task automatic std_rom();
        fill_rom(32'd3);
        set_id(0, 16'h0001);
        set_id(1, 16'h0005);
        set_id(2, 16'h0002);
    endtask

    task automatic pulse_start(input logic [15:0] id);
        @(posedge clk); #1;
        find_id = id;
        start   = 1'b1;
        @(posedge clk); #1;
        start   = 1'b0;
    endtask

    task automatic do_scan(input logic [15:0] id, input bit second_start);
        int t;
        int d0;
        model(id);
        rd_log.delete();
        d0 = done_cnt;
        pulse_start(id);
        chk("busy_after_start", busy, 1);
        if (second_start) begin
            repeat (3) @(posedge clk);
            #1 start = 1'b1;
            @(posedge clk);
            #1 start = 1'b0;
        end
        t = 0;
        @(negedge clk);
        while (!done && t < LIM) begin
            @(negedge clk);
            t++;
        end
        chk("done_seen", done, 1);
        chk("found", found, exp_found);
        chk("dev_index", dev_index, exp_idx);
        chk("dev_info", dev_info, exp_info);
        chk("dev_mem_off", dev_mem_off, exp_off);
        chk("dev_mem_size", dev_mem_size, exp_size);
        chk("num_devices", num_devices, exp_num);
        chk("timeout_err", timeout_err, 0);
        chk("busy_at_done", busy, 0);
        chk("n_reads", rd_log.size(), exp_adr.size());
        for (int i = 0; i < rd_log.size() && i < exp_adr.size(); i++)
            chk($sformatf("rd_adr%0d", i), rd_log[i], exp_adr[i]);
        @(negedge clk);
        chk("done_one_cycle", done, 0);
        chk("done_count", done_cnt - d0, 1);
        chk("found_held", found, exp_found);
    endtask

    initial begin
        int t;
        int d0;
        int hits;
        rst = 1'b0; start = 1'b0; find_id = '0; mute = 1'b0;
        fill_rom(32'd0);

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_found", found, 0);
        chk("rst_timeout_err", timeout_err, 0);
        chk("rst_num", num_devices, 0);
        chk("rst_idx", dev_index, 0);
        chk("rst_info", dev_info, 0);
        chk("rst_off", dev_mem_off, 0);
        chk("rst_size", dev_mem_size, 0);
        chk("rst_cyc", cyc, 0);
        chk("rst_stb", stb, 0);
        chk("rst_adr", adr, 0);
        chk("rst_we", we, 0);
        chk("rst_dat_o", dat_o, 0);
        @(negedge clk) rst = 1'b1;

        // Hit on the middle entry; the third entry must not be touched.
        std_rom();
        do_scan(16'h0005, 0);
        chk("t1_index", dev_index, 1);
        chk("t1_off", dev_mem_off, rom[10]);
        chk("t1_size", dev_mem_size, rom[11]);
        hits = 0;
        foreach (rd_log[i]) if (rd_log[i] == BASE + 32'd12) hits++;
        chk("t1_entry2_reads", hits, 0);

        do_scan(16'h0009, 0);
        chk("t2_reads", rd_log.size(), 4);
        chk("t2_num", num_devices, 3);

        rom[1] = 32'd0;
        do_scan(16'h0005, 0);
        chk("t3_reads", rd_log.size(), 1);
        if (rd_log.size() > 0) chk("t3_adr", rd_log[0], BASE + 32'd1);

        // Dead slave: everything resolves exactly TO cycles after stb rises.
        std_rom();
        mute = 1'b1;
        d0 = done_cnt;
        pulse_start(16'h0005);
        t = 0;
        @(negedge clk);
        while (!stb && t < LIM) begin
            @(negedge clk);
            t++;
        end
        chk("t4_stb_rose", stb, 1);
        repeat (TO - 1) @(negedge clk);
        chk("t4_cyc_before", cyc, 1);
        chk("t4_done_before", done, 0);
        @(negedge clk);
        chk("t4_cyc", cyc, 0);
        chk("t4_stb", stb, 0);
        chk("t4_done", done, 1);
        chk("t4_timeout_err", timeout_err, 1);
        chk("t4_found", found, 0);
        mute = 1'b0;
        repeat (5) @(negedge clk);
        chk("t4_err_held", timeout_err, 1);
        chk("t4_done_count", done_cnt - d0, 1);

        // Reset while reading the info word of the matching entry.
        std_rom();
        pulse_start(16'h0005);
        t = 0;
        @(negedge clk);
        while (!(stb && adr == BASE + 32'd9) && t < LIM) begin
            @(negedge clk);
            t++;
        end
        chk("t5_in_rd_info", {31'd0, stb && adr == BASE + 32'd9}, 1);
        d0 = done_cnt;
        rst = 1'b0;
        #1;
        chk("t5_cyc", cyc, 0);
        chk("t5_stb", stb, 0);
        chk("t5_busy", busy, 0);
        #1 rst = 1'b1;
        repeat (20) @(negedge clk);
        chk("t5_no_done", done_cnt - d0, 0);
        do_scan(16'h0005, 0);

        // Over-long table with a second start mid-scan.
        fill_rom(32'd40);
        for (int i = 0; i < 40; i++) set_id(i, 16'h0100 + 16'(i));
        do_scan(16'h0009, 1);
        chk("t6_reads", rd_log.size(), 17);

        rom[1] = 32'h0000_0103;
        do_scan(16'h0009, 0);
        chk("clamp_wide_reads", rd_log.size(), 17);

        for (int it = 0; it < 12; it++) begin
            fill_rom(32'($urandom_range(0, 24)));
            for (int i = 0; i < 40; i++) set_id(i, 16'($urandom_range(1, 8)));
            do_scan(16'($urandom_range(1, 10)), 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
